// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if
//   Command and issue bundle for alu_cmd_issuer.
//   master : command source and downstream consumer (drives Cmd_* and Stall)
//   slave  : the issuer (drives Cmd_Ready, issued operands, enables, tags)
//   Upstream  : Cmd_Valid, Cmd_Ready, Cmd_FUN[3:0], Cmd_A, Cmd_B, Cmd_Tag[3:0]
//   Backpress : Stall
//   Issue     : A, B, ALU_FUN[3:0], Arith/Logic/CMP/Shift_Enable
//   Results   : Out_Valid, Out_Tag[3:0], Err_Valid, Err_Tag[3:0]
interface alu_cmd_issuer_if #(
    parameter int In_out = 16
);
    logic              Cmd_Valid;
    logic              Cmd_Ready;
    logic [3:0]        Cmd_FUN;
    logic [In_out-1:0] Cmd_A;
    logic [In_out-1:0] Cmd_B;
    logic [3:0]        Cmd_Tag;
    logic              Stall;
    logic [In_out-1:0] A;
    logic [In_out-1:0] B;
    logic [3:0]        ALU_FUN;
    logic              Arith_Enable;
    logic              Logic_Enable;
    logic              CMP_Enable;
    logic              Shift_Enable;
    logic              Out_Valid;
    logic [3:0]        Out_Tag;
    logic              Err_Valid;
    logic [3:0]        Err_Tag;

    modport master (
        output Cmd_Valid, Cmd_FUN, Cmd_A, Cmd_B, Cmd_Tag, Stall,
        input  Cmd_Ready, A, B, ALU_FUN,
        input  Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
        input  Out_Valid, Out_Tag, Err_Valid, Err_Tag
    );

    modport slave (
        input  Cmd_Valid, Cmd_FUN, Cmd_A, Cmd_B, Cmd_Tag, Stall,
        output Cmd_Ready, A, B, ALU_FUN,
        output Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
        output Out_Valid, Out_Tag, Err_Valid, Err_Tag
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Buffers ALU commands in a DEPTH-entry FIFO and issues one per cycle to the
//   functional units, asserting exactly one unit enable per issue. Out_Valid /
//   Out_Tag follow the enable by one cycle to line up with the registered unit
//   result.
//   Ports:
//     CLK  - sole clock, rising edge
//     RST  - synchronous active-high reset, overrides push, pop and Stall
//     bus  - alu_cmd_issuer_if.slave (command input, issue outputs, tags)
//   Parameters:
//     In_out - operand width
//     DEPTH  - FIFO entries, power of two, >= 2
//   Optional feature macro: ALU_DIV_ZERO_CHECK_EN
//     When defined, a head entry with FUN=4'b0011 and B=0 is popped without
//     issue and reported on Err_Valid/Err_Tag. When undefined it issues
//     normally and Err_Valid/Err_Tag are tied to 0.
module alu_cmd_issuer #(
    parameter int In_out = 16,
    parameter int DEPTH  = 4
) (
    input logic            CLK,
    input logic            RST,
    alu_cmd_issuer_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [3:0]        fun;
        logic [In_out-1:0] a;
        logic [In_out-1:0] b;
        logic [3:0]        tag;
    } entry_t;

    // Unit decode: bit0 Arith, bit1 Logic, bit2 CMP, bit3 Shift.
    function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
        unit_onehot = 4'b0001 << sel;
    endfunction

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [In_out-1:0] a_q, a_d;
    logic [In_out-1:0] b_q, b_d;
    logic [3:0]        fun_q, fun_d;
    logic [3:0]        en_q, en_d;
    logic [3:0]        iss_tag_q, iss_tag_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_tag_q, out_tag_d;

    logic   cmd_ready;
    logic   push;
    logic   pop;
    logic   div_err;
    logic   issue;
    entry_t head;
    entry_t wr_entry;

    // Ready depends only on registered occupancy, so a pop in the same cycle
    // cannot let a new command in.
    assign cmd_ready = (count_q < DEPTH_C);
    assign push      = bus.Cmd_Valid && cmd_ready;
    assign pop       = (count_q != '0) && !bus.Stall;
    assign head      = mem_q[rd_ptr_q];
    assign wr_entry  = '{fun: bus.Cmd_FUN, a: bus.Cmd_A, b: bus.Cmd_B, tag: bus.Cmd_Tag};

`ifdef ALU_DIV_ZERO_CHECK_EN
    assign div_err = pop && (head.fun == 4'b0011) && (head.b == '0);
`else
    assign div_err = 1'b0;
`endif

    // A divide-by-zero entry is still popped, it just never reaches a unit.
    assign issue = pop && !div_err;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        en_d        = 4'b0000;
        iss_tag_d   = iss_tag_q;
        out_valid_d = |en_q;
        out_tag_d   = (|en_q) ? iss_tag_q : out_tag_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (issue) begin
            a_d       = head.a;
            b_d       = head.b;
            fun_d     = head.fun;
            en_d      = unit_onehot(head.fun[3:2]);
            iss_tag_d = head.tag;
        end
    end

    // Stage boundary: command storage (data only, no reset needed)
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Stage boundary: issue register and result-alignment register
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            en_q        <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            en_q        <= en_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Tag of the command currently at the units; only consumed when en_q is set.
    always_ff @(posedge CLK) begin
        iss_tag_q <= iss_tag_d;
    end

`ifdef ALU_DIV_ZERO_CHECK_EN
    logic       err_valid_q, err_valid_d;
    logic [3:0] err_tag_q, err_tag_d;

    always_comb begin
        err_valid_d = 1'b0;
        err_tag_d   = err_tag_q;
        if (div_err) begin
            err_valid_d = 1'b1;
            err_tag_d   = head.tag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_valid_q <= 1'b0;
            err_tag_q   <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_tag_q   <= err_tag_d;
        end
    end

    assign bus.Err_Valid = err_valid_q;
    assign bus.Err_Tag   = err_tag_q;
`else
    assign bus.Err_Valid = 1'b0;
    assign bus.Err_Tag   = 4'b0000;
`endif

    assign bus.Cmd_Ready    = cmd_ready;
    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.ALU_FUN      = fun_q;
    assign bus.Arith_Enable = en_q[0];
    assign bus.Logic_Enable = en_q[1];
    assign bus.CMP_Enable   = en_q[2];
    assign bus.Shift_Enable = en_q[3];
    assign bus.Out_Valid    = out_valid_q;
    assign bus.Out_Tag      = out_tag_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0]   fun;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   tag;
    } cmd_t;

    typedef struct {
        logic [3:0] en;
        logic       err;
        logic [3:0] tag;
        int         cyc;
    } iss_t;

    typedef struct {
        logic [3:0] tag;
        int         cyc;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_cmd_issuer_if #(.In_out(W)) bus ();

    alu_cmd_issuer #(.In_out(W), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rst_cyc = -1;

    cmd_t mq[$];
    iss_t exp_iss[$];
    out_t exp_out[$];
    logic [W-1:0] cur_a   = '0;
    logic [W-1:0] cur_b   = '0;
    logic [3:0]   cur_fun = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO as a queue, rules applied at each rising edge.
    always @(posedge clk) begin
        bit   can_push;
        bit   can_pop;
        cmd_t c;
        iss_t ie;
        out_t oe;
        cyc++;
        if (rst) begin
            mq.delete();
            exp_iss.delete();
            exp_out.delete();
            cur_a   = '0;
            cur_b   = '0;
            cur_fun = '0;
            rst_cyc = cyc;
        end else begin
            can_push = bus.Cmd_Valid && (mq.size() < DEPTH);
            can_pop  = (mq.size() > 0) && !bus.Stall;
            if (can_pop) begin
                c = mq.pop_front();
                ie.cyc = cyc;
                ie.tag = c.tag;
`ifdef ALU_DIV_ZERO_CHECK_EN
                if (c.fun == 4'b0011 && c.b == 0) begin
                    ie.en  = 4'b0000;
                    ie.err = 1'b1;
                    exp_iss.push_back(ie);
                end else
`endif
                begin
                    ie.en  = 4'b0001 << c.fun[3:2];
                    ie.err = 1'b0;
                    exp_iss.push_back(ie);
                    cur_a   = c.a;
                    cur_b   = c.b;
                    cur_fun = c.fun;
                    oe.tag  = c.tag;
                    oe.cyc  = cyc + 1;
                    exp_out.push_back(oe);
                end
            end
            if (can_push) begin
                c.fun = bus.Cmd_FUN;
                c.a   = bus.Cmd_A;
                c.b   = bus.Cmd_B;
                c.tag = bus.Cmd_Tag;
                mq.push_back(c);
            end
        end
    end

    // Monitor: compare whenever the DUT presents an issue/err/result.
    always @(negedge clk) begin
        logic [3:0] en_v;
        iss_t ie;
        out_t oe;
        if (cyc > 0) begin
            en_v = {bus.Shift_Enable, bus.CMP_Enable, bus.Logic_Enable, bus.Arith_Enable};
            chk("cmd_ready", {31'd0, bus.Cmd_Ready}, {31'd0, (mq.size() < DEPTH)});
            chk("a_out", {16'd0, bus.A}, {16'd0, cur_a});
            chk("b_out", {16'd0, bus.B}, {16'd0, cur_b});
            chk("alu_fun", {28'd0, bus.ALU_FUN}, {28'd0, cur_fun});
            if (rst_cyc == cyc) begin
                chk("rst_out_tag", {28'd0, bus.Out_Tag}, 32'd0);
                chk("rst_err_tag", {28'd0, bus.Err_Tag}, 32'd0);
            end
            if ((|en_v) || bus.Err_Valid) begin
                if (exp_iss.size() == 0) begin
                    chk("unexpected_issue", {27'd0, bus.Err_Valid, en_v}, 32'd0);
                end else begin
                    ie = exp_iss.pop_front();
                    chk("issue_cycle", cyc, ie.cyc);
                    chk("enables", {28'd0, en_v}, {28'd0, ie.en});
                    chk("err_valid", {31'd0, bus.Err_Valid}, {31'd0, ie.err});
                    if (ie.err) chk("err_tag", {28'd0, bus.Err_Tag}, {28'd0, ie.tag});
                end
            end else if (exp_iss.size() > 0 && exp_iss[0].cyc <= cyc) begin
                ie = exp_iss.pop_front();
                chk("missing_issue", {27'd0, bus.Err_Valid, en_v}, {27'd0, ie.err, ie.en});
            end
            if (bus.Out_Valid) begin
                if (exp_out.size() == 0) begin
                    chk("unexpected_out_valid", {31'd0, bus.Out_Valid}, 32'd0);
                end else begin
                    oe = exp_out.pop_front();
                    chk("out_cycle", cyc, oe.cyc);
                    chk("out_tag", {28'd0, bus.Out_Tag}, {28'd0, oe.tag});
                end
            end else if (exp_out.size() > 0 && exp_out[0].cyc <= cyc) begin
                oe = exp_out.pop_front();
                chk("missing_out_valid", {31'd0, bus.Out_Valid}, 32'd1);
            end
        end
    end

    task automatic send(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] tag);
        bit done = 0;
        bit rdy;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            bus.Cmd_Valid = 1'b1;
            bus.Cmd_FUN   = fun;
            bus.Cmd_A     = a;
            bus.Cmd_B     = b;
            bus.Cmd_Tag   = tag;
            rdy = bus.Cmd_Ready;
            @(posedge clk);
            if (rdy) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: tag %0h not accepted, required acceptance within 20 cycles", tag);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.Cmd_Valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Cmd_Valid = 1'b0;
        bus.Cmd_FUN   = '0;
        bus.Cmd_A     = '0;
        bus.Cmd_B     = '0;
        bus.Cmd_Tag   = '0;
        bus.Stall     = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic latency
        send(4'b0000, 16'd5, 16'd3, 4'd1);
        idle(4);

        // Fill under stall, fifth held, then release
        @(negedge clk);
        bus.Stall = 1'b1;
        send(4'b0001, 16'h11, 16'h21, 4'd2);
        send(4'b0101, 16'h12, 16'h22, 4'd3);
        send(4'b1001, 16'h13, 16'h23, 4'd4);
        send(4'b1110, 16'h14, 16'h24, 4'd5);
        repeat (3) begin
            @(negedge clk);
            bus.Cmd_Valid = 1'b1;
            bus.Cmd_FUN   = 4'b0010;
            bus.Cmd_A     = 16'h15;
            bus.Cmd_B     = 16'h25;
            bus.Cmd_Tag   = 4'd6;
        end
        @(negedge clk);
        bus.Stall = 1'b0;
        send(4'b0010, 16'h15, 16'h25, 4'd6);
        idle(8);

        // One of each remaining unit, back to back
        send(4'b0111, 16'h0a0a, 16'h0505, 4'd8);
        send(4'b1010, 16'h1234, 16'h1233, 4'd9);
        send(4'b1101, 16'h8000, 16'h0004, 4'd10);
        idle(4);

        // Divide by zero candidate
        send(4'b0011, 16'd8, 16'd0, 4'd7);
        idle(4);

        // Reset with three buffered and one in flight
        @(negedge clk);
        bus.Cmd_Valid = 1'b0;
        bus.Stall     = 1'b1;
        send(4'b0000, 16'h31, 16'h41, 4'd11);
        send(4'b0100, 16'h32, 16'h42, 4'd12);
        send(4'b1000, 16'h33, 16'h43, 4'd13);
        send(4'b1100, 16'h34, 16'h44, 4'd14);
        @(negedge clk);
        bus.Cmd_Valid = 1'b0;
        bus.Stall     = 1'b0;
        @(negedge clk);
        bus.Stall = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.Stall = 1'b0;
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 79) == 0);
            bus.Cmd_Valid = ($urandom_range(0, 2) != 0);
            bus.Stall     = ($urandom_range(0, 3) == 0);
            bus.Cmd_FUN   = 4'($urandom);
            bus.Cmd_A     = 16'($urandom);
            bus.Cmd_B     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            bus.Cmd_Tag   = 4'($urandom);
        end

        // Drain
        @(negedge clk);
        rst       = 1'b0;
        bus.Stall = 1'b0;
        idle(12);
        chk("drain_fifo", mq.size(), 32'd0);
        chk("drain_issue", exp_iss.size(), 32'd0);
        chk("drain_out", exp_out.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter In_out, default 16, operand width.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries; power of two, >=2.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Cmd_Valid  input  1  upstream command present.
REQ-006 SHALL have port Cmd_Ready  output  1  FIFO can accept.
REQ-007 SHALL have port Cmd_FUN  input  4  opcode; [3:2] unit select, [1:0] unit operation.
REQ-008 SHALL have ports Cmd_A, Cmd_B  input  In_out  operands.
REQ-009 SHALL have port Cmd_Tag  input  4  command identifier.
REQ-010 SHALL have port Stall  input  1  downstream backpressure; blocks issue.
REQ-011 SHALL have ports A, B  output  In_out  issued operands.
REQ-012 SHALL have port ALU_FUN  output  4  issued opcode.
REQ-013 SHALL have ports Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  output  1 each  unit enables.
REQ-014 SHALL have ports Out_Valid  output  1 and Out_Tag  output  4  result-alignment marker.
REQ-015 SHALL have ports Err_Valid  output  1 and Err_Tag  output  4  rejected-command report.

Function
REQ-016 SHALL accept a command on a rising edge with Cmd_Valid=1 and Cmd_Ready=1, writing {FUN,A,B,Tag} at the FIFO tail.
REQ-017 SHALL drive Cmd_Ready = (count < DEPTH), registered state only; a same-cycle pop SHALL NOT raise Cmd_Ready.
REQ-018 SHALL issue the head entry on an edge where count>0 and Stall=0; one issue per cycle max.
REQ-019 SHALL, on issue, register A, B, ALU_FUN from the entry and assert exactly one enable for that cycle: FUN[3:2] 00 Arith, 01 Logic, 10 CMP, 11 Shift.
REQ-020 SHALL hold A, B, ALU_FUN and drive all enables 0 on cycles without issue.
REQ-021 SHALL assert Out_Valid with Out_Tag = issued tag exactly one cycle after its enable cycle, aligned with the registered unit output.
REQ-022 SHALL give minimum latency: command accepted at edge N, enable high after edge N+1, Out_Valid high after edge N+2.
REQ-023 SHALL allow simultaneous push and pop; count unchanged, FIFO order preserved.
REQ-024 SHALL ignore Cmd_Valid when Cmd_Ready=0 (full); no overwrite.
REQ-025 SHALL issue nothing while empty; no enable, no Out_Valid.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL hold the head entry while Stall=1; Out_Valid for the previously issued command still asserts.

Reset
REQ-028 SHALL, on a rising edge with RST=1, clear FIFO count and pointers, drive A=0, B=0, ALU_FUN=0, all enables 0, Out_Valid=0, Out_Tag=0, Err_Valid=0, Err_Tag=0, Cmd_Ready=1 after that edge.
REQ-029 SHALL discard all buffered and in-flight commands on reset mid-operation; no Out_Valid or Err_Valid follows.
REQ-030 SHALL give RST priority over push, pop and Stall.

Configuration
REQ-031 SHALL support macro ALU_DIV_ZERO_CHECK_EN.
REQ-032 SHALL, with ALU_DIV_ZERO_CHECK_EN defined, pop a head entry with FUN=4'b0011 and B=0 without asserting any enable or updating A/B/ALU_FUN, and instead pulse Err_Valid=1 with Err_Tag=tag for that cycle; no Out_Valid follows.
REQ-033 SHALL, without ALU_DIV_ZERO_CHECK_EN, issue such commands normally and tie Err_Valid and Err_Tag to 0.

Verification
REQ-034 SHALL cover: reset, push FUN=0000 A=5 B=3 Tag=1 at edge N -> Arith_Enable=1, A=5, B=3 after N+1; Out_Valid=1, Out_Tag=1 after N+2.
REQ-035 SHALL cover: Stall=1, push 5 commands back-to-back (DEPTH=4) -> 4 accepted, Cmd_Ready=0, 5th held; release Stall -> issues tags in order, one per cycle.
REQ-036 SHALL cover: full FIFO, Stall=0, Cmd_Valid=1 -> pop occurs, push waits one cycle (Cmd_Ready low that edge).
REQ-037 SHALL cover: push FUN=0111, 1010, 1101 -> Logic, CMP, Shift enables respectively, one each, exactly one enable high per cycle.
REQ-038 SHALL cover (macro defined): FUN=0011 A=8 B=0 Tag=7 -> Err_Valid=1, Err_Tag=7, all enables 0; macro undefined -> Arith_Enable=1, Err_Valid stays 0.
REQ-039 SHALL cover: RST=1 with 3 entries buffered and one in flight -> no Out_Valid afterwards, Cmd_Ready=1, count=0.
